zcash_axi_lite_responder: RTL

// - AXI-lite slave/responder that terminates the zcash register window of the OCL path.
// - Upstream decode strips the window base, so addresses arrive offset-relative.
// - Provides version/control/scratch/status registers, stream packet counters and a W1C event register.
// - Sits in cl_zcash, behind the OCL address decoder, alongside the AXI-stream FIFO bridge.

---
 rtl/zcash_axi_lite_pkg.sv | 49 ++++
 rtl/if_axi_lite.sv | 37 +++
 rtl/zcash_sat_counter.sv | 32 +++
 rtl/zcash_axi_lite_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/zcash_axi_lite_pkg.sv
// Shared definitions for the zcash AXI-lite register window:
// register offsets, response codes, event bits and FSM states.
package zcash_axi_lite_pkg;

   localparam logic [4:0] REG_VERSION = 5'h00;
   localparam logic [4:0] REG_CONTROL = 5'h04;
   localparam logic [4:0] REG_SCRATCH = 5'h08;
   localparam logic [4:0] REG_STATUS  = 5'h0C;
   localparam logic [4:0] REG_RX_CNT  = 5'h10;
   localparam logic [4:0] REG_TX_CNT  = 5'h14;
   localparam logic [4:0] REG_EVENT   = 5'h18;
   localparam logic [4:0] REG_CNT_CLR = 5'h1C;

   localparam int unsigned REG_SPAN = 32;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_e;

   localparam int EVT_RX_SAT = 0;
   localparam int EVT_TX_SAT = 1;
   localparam int EVT_BAD    = 2;
   localparam int EVT_BITS   = 3;

   typedef enum logic {
      WR_IDLE,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_e;

   function automatic logic [31:0] strb_merge(
      input logic [31:0] i_old,
      input logic [31:0] i_new,
      input logic [3:0]  i_strb
   );
      logic [31:0] v;
      v = i_old;
      for (int b = 0; b < 4; b++) begin
         if (i_strb[b]) v[b*8 +: 8] = i_new[b*8 +: 8];
      end
      return v;
   endfunction

endpackage

// File: rtl/if_axi_lite.sv
// AXI-lite register access channel (aw/w/b/ar/r) with
// sink (responder) and source (requester) views.
interface if_axi_lite #(
   parameter int A_BITS = 32
);
   logic              awvalid;
   logic              awready;
   logic [A_BITS-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [A_BITS-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;

   modport sink (
      input  awvalid, awaddr, wvalid, wdata, wstrb,
      input  bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp,
      output arready, rvalid, rdata, rresp
   );

   modport source (
      output awvalid, awaddr, wvalid, wdata, wstrb,
      output bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp,
      input  arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/zcash_sat_counter.sv
// Saturating packet counter; o_sat flags an increment that lands
// on or beyond the ceiling, clear always takes priority.
module zcash_sat_counter
   import zcash_axi_lite_pkg::*;
#(
   parameter int CNT_BITS = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_inc,
   input  logic                i_clr,
   output logic [CNT_BITS-1:0] o_cnt,
   output logic                o_sat
);
   localparam logic [CNT_BITS-1:0] MAX = '1;

   logic [CNT_BITS-1:0] r_cnt;

   assign o_cnt = r_cnt;
   assign o_sat = i_inc && !i_clr &&
                  (r_cnt >= MAX - CNT_BITS'(1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && r_cnt != MAX) begin
         r_cnt <= r_cnt + CNT_BITS'(1);
      end
   end
endmodule

// File: rtl/zcash_axi_lite_responder.sv
// AXI-lite responder terminating the zcash OCL register window:
// version/control/scratch/status, packet counters and W1C events.
module zcash_axi_lite_responder
   import zcash_axi_lite_pkg::*;
#(
   parameter int          A_BITS     = 32,
   parameter int unsigned SPACE_BYTS = 4096,
   parameter logic [31:0] VERSION    = 32'h0001_0000,
   parameter int          CNT_BITS   = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   if_axi_lite.sink      rx_axi_lite_if,
   input  logic          i_rx_pkt,
   input  logic          i_tx_pkt,
   input  logic [31:0]   i_status,
   output logic [30:0]   o_ctl,
   output logic          o_soft_rst
);
   localparam int unsigned MAP_END =
      (SPACE_BYTS < REG_SPAN) ? SPACE_BYTS : REG_SPAN;

   wr_state_e         r_wst, w_wst_nx;
   rd_state_e         r_rdst, w_rdst_nx;
   logic              r_aw_held, r_w_held;
   logic [A_BITS-1:0] r_awaddr, w_waddr;
   logic [31:0]       r_wdata, w_wdata;
   logic [3:0]        r_wstrb, w_wstrb;
   axi_resp_e         r_bresp, r_rresp;
   logic [31:0]       r_rdata, w_rd_data;
   logic [30:0]       r_ctl;
   logic [31:0]       r_scratch, w_ctl_new;
   logic [EVT_BITS-1:0] r_evt, w_evt_set, w_evt_clr;
   logic              r_soft_rst;

   logic w_aw_hs, w_w_hs, w_ar_hs;
   logic w_aw_have, w_w_have, w_commit;
   logic w_wr_map, w_rd_map, w_bad;
   logic [4:0] w_wr_off, w_rd_off;
   logic w_wr_ctl, w_wr_scr, w_wr_evt, w_wr_clr;
   logic w_rx_clr, w_tx_clr, w_rx_sat, w_tx_sat;
   logic [CNT_BITS-1:0] w_rx_cnt, w_tx_cnt;

   // Handshake channel outputs
   assign rx_axi_lite_if.awready =
      !i_rst && r_wst == WR_IDLE && !r_aw_held;
   assign rx_axi_lite_if.wready =
      !i_rst && r_wst == WR_IDLE && !r_w_held;
   assign rx_axi_lite_if.arready = !i_rst && r_rdst == RD_IDLE;
   assign rx_axi_lite_if.bvalid  = (r_wst == WR_RESP);
   assign rx_axi_lite_if.bresp   = r_bresp;
   assign rx_axi_lite_if.rvalid  = (r_rdst == RD_DATA);
   assign rx_axi_lite_if.rdata   = r_rdata;
   assign rx_axi_lite_if.rresp   = r_rresp;
   assign o_ctl      = r_ctl;
   assign o_soft_rst = r_soft_rst;

   assign w_aw_hs = rx_axi_lite_if.awvalid &&
                    rx_axi_lite_if.awready;
   assign w_w_hs  = rx_axi_lite_if.wvalid && rx_axi_lite_if.wready;
   assign w_ar_hs = rx_axi_lite_if.arvalid &&
                    rx_axi_lite_if.arready;

   // Commit in the same cycle the second half of the pair arrives
   assign w_aw_have = r_aw_held || w_aw_hs;
   assign w_w_have  = r_w_held || w_w_hs;
   assign w_commit  = r_wst == WR_IDLE && w_aw_have && w_w_have;

   assign w_waddr = r_aw_held ? r_awaddr : rx_axi_lite_if.awaddr;
   assign w_wdata = r_w_held ? r_wdata : rx_axi_lite_if.wdata;
   assign w_wstrb = r_w_held ? r_wstrb : rx_axi_lite_if.wstrb;

   assign w_wr_off = {w_waddr[4:2], 2'b00};
   assign w_rd_off = {rx_axi_lite_if.araddr[4:2], 2'b00};
   assign w_wr_map = w_waddr < A_BITS'(MAP_END);
   assign w_rd_map = rx_axi_lite_if.araddr < A_BITS'(MAP_END);

   always_comb begin
      w_wr_ctl = 1'b0;
      w_wr_scr = 1'b0;
      w_wr_evt = 1'b0;
      w_wr_clr = 1'b0;
      if (w_commit && w_wr_map) begin
         unique case (w_wr_off)
            REG_CONTROL: w_wr_ctl = 1'b1;
            REG_SCRATCH: w_wr_scr = 1'b1;
            REG_EVENT:   w_wr_evt = 1'b1;
            REG_CNT_CLR: w_wr_clr = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rd_data = '0;
      if (w_rd_map) begin
         unique case (w_rd_off)
            REG_VERSION: w_rd_data = VERSION;
            REG_CONTROL: w_rd_data = {r_ctl, 1'b0};
            REG_SCRATCH: w_rd_data = r_scratch;
            REG_STATUS:  w_rd_data = i_status;
            REG_RX_CNT:  w_rd_data = 32'(w_rx_cnt);
            REG_TX_CNT:  w_rd_data = 32'(w_tx_cnt);
            REG_EVENT:   w_rd_data = 32'(r_evt);
            default:     w_rd_data = '0;
         endcase
      end
   end

   assign w_ctl_new = strb_merge({r_ctl, 1'b0}, w_wdata, w_wstrb);
   assign w_rx_clr  = w_wr_clr && w_wstrb[0] && w_wdata[0];
   assign w_tx_clr  = w_wr_clr && w_wstrb[0] && w_wdata[1];
   assign w_bad     = (w_commit && !w_wr_map) ||
                      (w_ar_hs && !w_rd_map);
   assign w_evt_set = {w_bad, w_tx_sat, w_rx_sat};
   assign w_evt_clr = w_wr_evt ?
      (w_wdata[EVT_BITS-1:0] & {EVT_BITS{w_wstrb[0]}}) : '0;

   always_comb begin
      w_wst_nx = r_wst;
      unique case (r_wst)
         WR_IDLE: if (w_commit) w_wst_nx = WR_RESP;
         WR_RESP: if (rx_axi_lite_if.bready) w_wst_nx = WR_IDLE;
      endcase
   end

   always_comb begin
      w_rdst_nx = r_rdst;
      unique case (r_rdst)
         RD_IDLE: if (w_ar_hs) w_rdst_nx = RD_DATA;
         RD_DATA: if (rx_axi_lite_if.rready) w_rdst_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wst  <= WR_IDLE;
         r_rdst <= RD_IDLE;
      end else begin
         r_wst  <= w_wst_nx;
         r_rdst <= w_rdst_nx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bresp   <= w_wr_map ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= rx_axi_lite_if.awaddr;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= rx_axi_lite_if.wdata;
            r_wstrb  <= rx_axi_lite_if.wstrb;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_data;
         r_rresp <= w_rd_map ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctl      <= '0;
         r_scratch  <= '0;
         r_evt      <= '0;
         r_soft_rst <= 1'b0;
      end else begin
         r_soft_rst <= w_wr_ctl && w_ctl_new[0];
         if (w_wr_ctl) r_ctl <= w_ctl_new[31:1];
         if (w_wr_scr) begin
            r_scratch <= strb_merge(r_scratch, w_wdata, w_wstrb);
         end
         // Hardware set beats a same-cycle W1C
         r_evt <= (r_evt & ~w_evt_clr) | w_evt_set;
      end
   end

   zcash_sat_counter #(.CNT_BITS(CNT_BITS)) u_rx_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (i_rx_pkt),
      .i_clr (w_rx_clr),
      .o_cnt (w_rx_cnt),
      .o_sat (w_rx_sat)
   );

   zcash_sat_counter #(.CNT_BITS(CNT_BITS)) u_tx_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (i_tx_pkt),
      .i_clr (w_tx_clr),
      .o_cnt (w_tx_cnt),
      .o_sat (w_tx_sat)
   );
endmodule
